// File: rtl/tap_seq_counter_if.sv
// Control/status bundle for tap_seq_counter. The master side drives the controls and
// the slave side (the counter) returns count and flags.
interface tap_seq_counter_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             up_dn;
   logic             mode;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrap;
   logic             busy;
   logic             done;

   modport master (
      output en, up_dn, mode, load, load_val, start,
      input  count, tc, wrap, busy, done
   );

   modport slave (
      input  en, up_dn, mode, load, load_val, start,
      output count, tc, wrap, busy, done
   );
endinterface

// File: rtl/tap_seq_counter.sv
// Modulo-MODULO up/down counter with free-run and one-shot sequencer modes.
// One-shot mode walks exactly one pass over the range, then pulses done for a cycle.
module tap_seq_counter #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned MODULO = 16
) (
   input logic               clk,
   input logic               rst,
   tap_seq_counter_if.slave  bus
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULO - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             busy_q, done_q;

   logic [WIDTH-1:0] term_val;
   logic             at_term;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] load_clamped;

   // Terminal value depends on the live direction, so tc tracks up_dn changes at once.
   assign term_val     = bus.up_dn ? MaxVal : '0;
   assign at_term      = (count_q == term_val);
   assign load_clamped = (bus.load_val > MaxVal) ? MaxVal : bus.load_val;

   // One modular step in the current direction; wraps at the range ends.
   always_comb begin
      step_val = count_q;
      if (bus.up_dn) begin
         step_val = at_term ? '0 : count_q + WIDTH'(1);
      end else begin
         step_val = at_term ? MaxVal : count_q - WIDTH'(1);
      end
   end

   // Sequencer next state; dropping mode forces IDLE, load never changes the state.
   always_comb begin
      state_d = state_q;
      if (!bus.mode) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (bus.start && !bus.load) state_d = StRun;
            StRun:   if (bus.en && at_term && !bus.load) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // Count and wrap next value; priority is load, then start, then enabled count.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (bus.load) begin
         count_d = load_clamped;
      end else if (!bus.mode) begin
         if (bus.en) begin
            count_d = step_val;
            wrap_d  = at_term;
         end
      end else begin
         unique case (state_q)
            StIdle:  if (bus.start) count_d = bus.up_dn ? '0 : MaxVal;
            // A pass never wraps: at the terminal value the count just holds.
            StRun:   if (bus.en && !at_term) count_d = step_val;
            StDone:  count_d = count_q;
            default: count_d = count_q;
         endcase
      end
   end

   // State, count and flag registers; busy/done are flopped decodes of the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         count_q <= '0;
         wrap_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wrap_q  <= wrap_d;
         busy_q  <= (state_d == StRun);
         done_q  <= (state_d == StDone);
      end
   end

   // Drive the status outputs.
   always_comb begin
      bus.count = count_q;
      bus.tc    = at_term;
      bus.wrap  = wrap_q;
      bus.busy  = busy_q;
      bus.done  = done_q;
   end

endmodule

// File: tb/tb_tap_seq_counter.sv
// Scoreboard bench for tap_seq_counter (WIDTH=4, MODULO=10): the driver pushes the
// expected post-edge outputs from a behavioural model, a negedge monitor pops and compares.
module tb_tap_seq_counter;
   localparam int W = 4;
   localparam int M = 10;

   typedef struct {
      int         cyc;
      logic [3:0] count;
      logic       wrap;
      logic       busy;
      logic       done;
      string      tag;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_vec;
   int   n_bad;
   exp_t q[$];
   string phase;

   // Behavioural model state
   int m_count;
   bit m_busy;
   bit m_done;
   bit m_wrap;

   tap_seq_counter_if #(.WIDTH(W)) bus ();

   tap_seq_counter #(.WIDTH(W), .MODULO(M)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   function automatic void push_exp(int at_cyc);
      exp_t e;
      e.cyc   = at_cyc;
      e.count = 4'(m_count);
      e.wrap  = m_wrap;
      e.busy  = m_busy;
      e.done  = m_done;
      e.tag   = phase;
      q.push_back(e);
   endfunction

   // One clock of spec behaviour, written from the rules rather than from any state machine.
   function automatic void model_step(bit en, bit up, bit mode, bit load, int lv, bit start);
      int term = up ? M - 1 : 0;
      int nxt  = m_count;
      bit nb   = 1'b0;
      bit nd   = 1'b0;
      if (load) nxt = (lv > M - 1) ? M - 1 : lv;
      else if (!mode) begin
         if (en) nxt = up ? (m_count + 1) % M : (m_count + M - 1) % M;
      end else if (m_busy) begin
         if (en) begin
            if (m_count == term) nd = 1'b1;
            else nxt = m_count + (up ? 1 : -1);
         end
      end else if (!m_done && start) nxt = up ? 0 : M - 1;
      if (mode) begin
         if (m_busy) nb = !nd;
         else if (!m_done && start && !load) nb = 1'b1;
      end
      m_wrap  = !load && !mode && en && (up ? (nxt < m_count) : (nxt > m_count));
      m_count = nxt;
      m_busy  = nb;
      m_done  = nd;
   endfunction

   // Called at posedge+1: apply inputs for the next edge, predict, advance one cycle.
   task automatic step(bit en, bit up, bit mode, bit load, int lv, bit start);
      bus.en       = en;
      bus.up_dn    = up;
      bus.mode     = mode;
      bus.load     = load;
      bus.load_val = 4'(lv);
      bus.start    = start;
      model_step(en, up, mode, load, lv, start);
      push_exp(cyc + 1);
      @(posedge clk);
      #1;
   endtask

   // Mid-cycle asynchronous reset; outputs must clear before the next clock edge.
   task automatic do_reset();
      #2;
      rst = 1'b1;
      q.delete();
      m_count = 0;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_wrap  = 1'b0;
      push_exp(cyc);
      @(posedge clk);
      #1;
      rst = 1'b0;
      push_exp(cyc);
   endtask

   // Monitor: compare every expectation that has come due.
   initial begin
      exp_t e;
      logic exp_tc;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            e      = q.pop_front();
            exp_tc = (e.count == 4'(bus.up_dn ? M - 1 : 0));
            n_vec++;
            if (bus.count !== e.count || bus.wrap !== e.wrap || bus.busy !== e.busy ||
                bus.done !== e.done || bus.tc !== exp_tc) begin
               n_bad++;
               $display("FAIL %s cyc=%0d got count=%0d wrap=%b busy=%b done=%b tc=%b exp count=%0d wrap=%b busy=%b done=%b tc=%b",
                        e.tag, cyc, bus.count, bus.wrap, bus.busy, bus.done, bus.tc,
                        e.count, e.wrap, e.busy, e.done, exp_tc);
            end
         end
      end
   end

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst   = 1'b0;
      bus.en = 1'b0; bus.up_dn = 1'b1; bus.mode = 1'b0;
      bus.load = 1'b0; bus.load_val = '0; bus.start = 1'b0;
      @(posedge clk);
      #1;
      phase = "reset";
      do_reset();

      phase = "free_up";
      for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);

      phase = "free_down";
      do_reset();
      for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 0);

      phase = "load_clamp";
      step(1, 1, 0, 1, 12, 0);
      step(0, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);

      phase = "oneshot";
      do_reset();
      step(1, 1, 1, 0, 0, 1);
      for (int i = 1; i < 14; i++) step(1, 1, 1, 0, 0, (i == 5));

      phase = "oneshot_gap";
      step(1, 1, 1, 0, 0, 1);
      for (int i = 0; i < 24; i++) step(i % 2 == 0, 1, 1, 0, 0, 0);

      phase = "abort";
      step(1, 1, 1, 0, 0, 1);
      for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0, 0);
      do_reset();
      phase = "restart";
      step(1, 0, 1, 0, 0, 1);
      for (int i = 0; i < 12; i++) step(1, 0, 1, 0, 0, 0);

      phase = "random";
      begin
         bit md = 1'b1;
         bit up = 1'b1;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 2) md = ~md;
            if ($urandom_range(99) < 5) up = ~up;
            if ($urandom_range(999) < 5) do_reset();
            else step($urandom_range(99) < 80, up, md, $urandom_range(99) < 4,
                      int'($urandom_range(15)), $urandom_range(99) < 10);
         end
      end

      bus.en = 1'b0; bus.load = 1'b0; bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_vec++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got %0d pending expectations, need 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
